// File: rtl/attribute_result_arbiter.sv
// Buffers per-group attribute results and schedules one per cycle onto a valid/ready stream.
// Define ATTR_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority (highest index).
module attribute_result_arbiter #(
   parameter int unsigned ATTRIBUTE_DATA_WIDTH = 135,
   parameter int unsigned DATA_GROUPS          = 4,
   parameter int unsigned DROP_CNT_WIDTH       = 16
) (
   input  logic                                     clk,
   input  logic                                     resetn,
   input  logic [DATA_GROUPS-1:0]                   valid_groups_i,
   input  logic [DATA_GROUPS*ATTRIBUTE_DATA_WIDTH-1:0] data_groups_i,
   output logic                                     valid_o,
   output logic [ATTRIBUTE_DATA_WIDTH-1:0]          data_o,
   output logic [DATA_GROUPS-1:0]                   grant_o,
   input  logic                                     ready_i,
   input  logic                                     clear_drops_i,
   output logic [DATA_GROUPS*DROP_CNT_WIDTH-1:0]    drop_count_o
);

   localparam int unsigned IdxW = (DATA_GROUPS > 1) ? $clog2(DATA_GROUPS) : 1;

   typedef enum logic {StEmpty, StFull} out_state_e;

   out_state_e                      state_q, state_d;
   logic [ATTRIBUTE_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [DATA_GROUPS-1:0]          out_grant_q, out_grant_d;
   logic [DATA_GROUPS-1:0]          pending_q, pending_d;
   logic [ATTRIBUTE_DATA_WIDTH-1:0] slot_q [DATA_GROUPS];
   logic [DROP_CNT_WIDTH-1:0]       drop_cnt_q [DATA_GROUPS];

   logic                            out_free;
   logic                            sel_valid;
   logic [IdxW-1:0]                 sel_idx;
   logic [DATA_GROUPS-1:0]          sel_oh;
   logic [DATA_GROUPS-1:0]          take_oh;
   logic [DATA_GROUPS-1:0]          capture;
   logic [DATA_GROUPS-1:0]          drop;

   assign out_free = (state_q == StEmpty) || ready_i;

`ifdef ATTR_ARB_ROUND_ROBIN_EN
   logic [IdxW-1:0] rr_ptr_q;

   // Scan from farthest to nearest so the candidate at ptr+1 is assigned last and wins.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      sel_valid = 1'b0;
      sel_idx   = rr_ptr_q;
      for (int k = DATA_GROUPS; k >= 1; k--) begin
         cand = (int'(rr_ptr_q) + k) % DATA_GROUPS;
         if (pending_q[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = IdxW'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rr_ptr_q <= IdxW'(DATA_GROUPS - 1);
      end else if (out_free && sel_valid) begin
         rr_ptr_q <= sel_idx;
      end
   end
`else
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int g = 0; g < DATA_GROUPS; g++) begin
         if (pending_q[g]) begin
            sel_valid = 1'b1;
            sel_idx   = IdxW'(g);
         end
      end
   end
`endif

   always_comb begin
      sel_oh          = '0;
      sel_oh[sel_idx] = sel_valid;
      take_oh         = out_free ? sel_oh : '0;
   end

   // A slot being drained this cycle can accept a new result without dropping.
   always_comb begin
      capture   = valid_groups_i & (~pending_q | take_oh);
      drop      = valid_groups_i & pending_q & ~take_oh;
      pending_d = (pending_q & ~take_oh) | capture;
   end

   always_comb begin
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_grant_d = out_grant_q;
      if (out_free) begin
         if (sel_valid) begin
            state_d     = StFull;
            out_data_d  = slot_q[sel_idx];
            out_grant_d = sel_oh;
         end else begin
            state_d     = StEmpty;
            out_data_d  = '0;
            out_grant_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= StEmpty;
         out_data_q  <= '0;
         out_grant_q <= '0;
         pending_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_grant_q <= out_grant_d;
         pending_q   <= pending_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int g = 0; g < DATA_GROUPS; g++) begin
         if (capture[g]) begin
            slot_q[g] <= data_groups_i[g*ATTRIBUTE_DATA_WIDTH +: ATTRIBUTE_DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int g = 0; g < DATA_GROUPS; g++) begin
         if (!resetn) begin
            drop_cnt_q[g] <= '0;
         end else if (clear_drops_i) begin
            drop_cnt_q[g] <= drop[g] ? DROP_CNT_WIDTH'(1) : '0;
         end else if (drop[g] && (drop_cnt_q[g] != '1)) begin
            drop_cnt_q[g] <= drop_cnt_q[g] + 1'b1;
         end
      end
   end

   assign valid_o = (state_q == StFull);
   assign data_o  = out_data_q;
   assign grant_o = out_grant_q;

   for (genvar g = 0; g < DATA_GROUPS; g++) begin : g_drop_out
      assign drop_count_o[g*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_cnt_q[g];
   end

endmodule

// File: tb/tb_attribute_result_arbiter.sv
// Scoreboard bench for attribute_result_arbiter; 2-bit drop counters exercise saturation.
module tb_attribute_result_arbiter;

   localparam int W  = 135;
   localparam int G  = 4;
   localparam int DW = 2;

   logic              clk = 1'b0;
   logic              resetn;
   logic [G-1:0]      valid_groups_i;
   logic [G*W-1:0]    data_groups_i;
   logic              valid_o;
   logic [W-1:0]      data_o;
   logic [G-1:0]      grant_o;
   logic              ready_i;
   logic              clear_drops_i;
   logic [G*DW-1:0]   drop_count_o;
   logic [W-1:0]      dg [G];

   typedef struct packed {
      logic [W-1:0] data;
      logic [G-1:0] grant;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks   = 0;
   int   failures = 0;

   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data;
   logic [G-1:0] prev_grant;

   always #5 clk = ~clk;

   for (genvar g = 0; g < G; g++) begin : g_pack
      assign data_groups_i[g*W +: W] = dg[g];
   end

   attribute_result_arbiter #(
      .ATTRIBUTE_DATA_WIDTH(W),
      .DATA_GROUPS         (G),
      .DROP_CNT_WIDTH      (DW)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .valid_groups_i(valid_groups_i),
      .data_groups_i (data_groups_i),
      .valid_o       (valid_o),
      .data_o        (data_o),
      .grant_o       (grant_o),
      .ready_i       (ready_i),
      .clear_drops_i (clear_drops_i),
      .drop_count_o  (drop_count_o)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn         = 1'b0;
      valid_groups_i = '0;
      clear_drops_i  = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   function automatic logic [DW-1:0] dcnt(input int g);
      return drop_count_o[g*DW +: DW];
   endfunction

   // Monitor: pops on every accepted beat and checks held outputs during a stall.
   always @(negedge clk) begin
      if (resetn && prev_stall) begin
         check("stall_valid", W'(valid_o), W'(1));
         check("stall_data", data_o, prev_data);
         check("stall_grant", W'(grant_o), W'(prev_grant));
      end
      if (resetn && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h grant=%0h required=none", data_o, grant_o);
         end else begin
            e = exp_q.pop_front();
            check("sb_data", data_o, e.data);
            check("sb_grant", W'(grant_o), W'(e.grant));
         end
      end
      prev_stall = resetn && valid_o && !ready_i;
      prev_data  = data_o;
      prev_grant = grant_o;
   end

   initial begin
      resetn         = 1'b0;
      ready_i        = 1'b0;
      valid_groups_i = '0;
      clear_drops_i  = 1'b0;
      for (int g = 0; g < G; g++) dg[g] = '0;
      tick();
      tick();
      resetn = 1'b1;
      check("rst_valid", W'(valid_o), W'(0));
      check("rst_data", data_o, W'(0));
      check("rst_grant", W'(grant_o), W'(0));
      check("rst_drops", W'(drop_count_o), W'(0));

      // Single result latency
      ready_i        = 1'b1;
      dg[1]          = W'(8'h5A);
      valid_groups_i = 4'b0010;
      exp_q.push_back('{data: W'(8'h5A), grant: 4'b0010});
      tick();
      valid_groups_i = '0;
      tick();
      check("lat_valid", W'(valid_o), W'(1));
      check("lat_data", data_o, W'(8'h5A));
      check("lat_grant", W'(grant_o), W'(4'b0010));
      tick();
      check("lat_idle_valid", W'(valid_o), W'(0));
      check("lat_idle_grant", W'(grant_o), W'(0));

      // Three simultaneous requests, back-to-back drain
      do_reset();
      ready_i = 1'b1;
      dg[0]   = W'(16'hA000);
      dg[2]   = W'(16'hA002);
      dg[3]   = W'(16'hA003);
      valid_groups_i = 4'b1101;
`ifdef ATTR_ARB_ROUND_ROBIN_EN
      exp_q.push_back('{data: W'(16'hA000), grant: 4'b0001});
      exp_q.push_back('{data: W'(16'hA002), grant: 4'b0100});
      exp_q.push_back('{data: W'(16'hA003), grant: 4'b1000});
`else
      exp_q.push_back('{data: W'(16'hA003), grant: 4'b1000});
      exp_q.push_back('{data: W'(16'hA002), grant: 4'b0100});
      exp_q.push_back('{data: W'(16'hA000), grant: 4'b0001});
`endif
      tick();
      valid_groups_i = '0;
      tick();
`ifdef ATTR_ARB_ROUND_ROBIN_EN
      check("burst_g_first", W'(grant_o), W'(4'b0001));
      tick();
      check("burst_g_second", W'(grant_o), W'(4'b0100));
      tick();
      check("burst_g_third", W'(grant_o), W'(4'b1000));
`else
      check("burst_g_first", W'(grant_o), W'(4'b1000));
      tick();
      check("burst_g_second", W'(grant_o), W'(4'b0100));
      tick();
      check("burst_g_third", W'(grant_o), W'(4'b0001));
`endif
      tick();
      check("burst_done", W'(valid_o), W'(0));

      // Stall with group 2 held; drops, clear, clear+drop, saturation
      do_reset();
      ready_i        = 1'b0;
      dg[2]          = W'(16'hB002);
      valid_groups_i = 4'b0100;
      exp_q.push_back('{data: W'(16'hB002), grant: 4'b0100});
      tick();
      valid_groups_i = '0;
      tick();
      dg[0]          = W'(16'hC000);
      valid_groups_i = 4'b0001;
      tick();
      dg[0] = W'(16'hC001);
      tick();
      dg[0] = W'(16'hC002);
      tick();
      valid_groups_i = '0;
      tick();
      check("drop_g0_two", W'(dcnt(0)), W'(2));
      tick();
      tick();
      clear_drops_i = 1'b1;
      tick();
      clear_drops_i = 1'b0;
      check("drop_clear", W'(dcnt(0)), W'(0));
      clear_drops_i  = 1'b1;
      dg[0]          = W'(16'hC003);
      valid_groups_i = 4'b0001;
      tick();
      clear_drops_i  = 1'b0;
      valid_groups_i = '0;
      check("drop_clear_coinc", W'(dcnt(0)), W'(1));
      dg[1]          = W'(16'hD000);
      valid_groups_i = 4'b0010;
      tick();
      dg[1] = W'(16'hD001);
      repeat (5) tick();
      valid_groups_i = '0;
      check("drop_sat_g1", W'(dcnt(1)), W'(3));
      check("drop_g0_kept", W'(dcnt(0)), W'(1));
`ifdef ATTR_ARB_ROUND_ROBIN_EN
      exp_q.push_back('{data: W'(16'hC000), grant: 4'b0001});
      exp_q.push_back('{data: W'(16'hD000), grant: 4'b0010});
`else
      exp_q.push_back('{data: W'(16'hD000), grant: 4'b0010});
      exp_q.push_back('{data: W'(16'hC000), grant: 4'b0001});
`endif
      ready_i = 1'b1;
      repeat (6) tick();

      // Reset while output full and three slots pending
      ready_i        = 1'b0;
      dg[3]          = W'(16'hE003);
      valid_groups_i = 4'b1000;
      tick();
      valid_groups_i = '0;
      tick();
      dg[0]          = W'(16'hE000);
      dg[1]          = W'(16'hE001);
      dg[2]          = W'(16'hE002);
      valid_groups_i = 4'b0111;
      tick();
      valid_groups_i = '0;
      check("pre_rst_valid", W'(valid_o), W'(1));
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      check("mid_rst_valid", W'(valid_o), W'(0));
      check("mid_rst_data", data_o, W'(0));
      check("mid_rst_grant", W'(grant_o), W'(0));
      check("mid_rst_drops", W'(drop_count_o), W'(0));
      ready_i = 1'b1;
      repeat (8) tick();
      check("post_rst_idle", W'(valid_o), W'(0));

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
      check("sb_drained", W'(exp_q.size()), W'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
